time_set_ctrl: RTL

- Input-side companion to the BCD watch core: turns two raw push-buttons into a debounced time-setting sequence.
- Emits BCD init digits plus a one-cycle load strobe on the watch init interface (hourdec_init, hourone_init, mindec_init, minone_init), which the watch core consumes.
- Snapshots the running time on entry, so editing starts from the current display value.
- Sits beside watch_bindec in the board top, between BTN pins and the watch.

---
 rtl/time_set_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: takes two raw push-buttons (mode, inc) and produces a debounced
// time-setting sequence. It loads BCD init digits into the watch core.
// Optional macro AUTOREPEAT_EN: while inc is held in a set state, an extra step
// is generated every REPEAT_CNT cycles after the initial press.
// Handshake: load is a one-cycle strobe, and the *_init digits are valid in that
// cycle. The digits also hold their value afterwards, so the watch may sample
// them any time it sees load high.
module time_set_ctrl #(
    parameter int DEBOUNCE_CNT = 10000,
    parameter int TIMEOUT_CNT  = 50000000
`ifdef AUTOREPEAT_EN
    , parameter int REPEAT_CNT = 25000000
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [3:0] hourdec_now,
    input  logic [3:0] hourone_now,
    input  logic [3:0] mindec_now,
    input  logic [3:0] minone_now,
    output logic [3:0] hourdec_init,
    output logic [3:0] hourone_init,
    output logic [3:0] mindec_init,
    output logic [3:0] minone_init,
    output logic       load,
    output logic       set_active,
    output logic [1:0] edit_sel
);

    localparam int DW = $clog2(DEBOUNCE_CNT + 1);
    localparam int TW = $clog2(TIMEOUT_CNT + 1);

    typedef enum logic [1:0] {RUN, SET_HOUR, SET_MIN, COMMIT} state_t;

    // Bit 0 is the mode button, bit 1 is the inc button.
    logic [1:0]         sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]         deb_q, deb_d, deb_dly_q, deb_dly_d, press_q, press_d;
    logic [1:0][DW-1:0] dcnt_q, dcnt_d;
    state_t             state_q, state_d;
    logic [7:0]         hour_q, hour_d, min_q, min_d;
    logic [TW-1:0]      idle_q, idle_d;
    logic               in_set, timeout, inc_step, rep_step;

    function automatic logic [7:0] next_hour(input logic [7:0] h);
        if (h == 8'h23)       return 8'h00;
        if (h[3:0] == 4'd9)   return {h[7:4] + 4'd1, 4'd0};
        return {h[7:4], h[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] next_min(input logic [7:0] m);
        if (m[3:0] != 4'd9)   return {m[7:4], m[3:0] + 4'd1};
        if (m[7:4] == 4'd5)   return 8'h00;
        return {m[7:4] + 4'd1, 4'd0};
    endfunction

    function automatic logic hour_ok(input logic [7:0] h);
        return (h[7:4] <= 4'd2) && (h[3:0] <= 4'd9) && !((h[7:4] == 4'd2) && (h[3:0] > 4'd3));
    endfunction

    function automatic logic min_ok(input logic [7:0] m);
        return (m[7:4] <= 4'd5) && (m[3:0] <= 4'd9);
    endfunction

    // Synchronize both raw buttons, debounce them, and form the rising-edge press pulses.
    always_comb begin
        sync1_d   = {btn_inc, btn_mode};
        sync2_d   = sync1_q;
        deb_d     = deb_q;
        dcnt_d    = '0;
        for (int b = 0; b < 2; b++) begin
            if (sync2_q[b] != deb_q[b]) begin
                if (dcnt_q[b] == DW'(DEBOUNCE_CNT - 1)) begin
                    deb_d[b] = ~deb_q[b];
                end else begin
                    dcnt_d[b] = dcnt_q[b] + DW'(1);
                end
            end
        end
        deb_dly_d = deb_q;
        press_d   = deb_q & ~deb_dly_q;
    end

    assign in_set   = (state_q == SET_HOUR) || (state_q == SET_MIN);
    assign timeout  = in_set && (idle_q == TW'(TIMEOUT_CNT - 1));
    assign inc_step = press_q[1] | rep_step;

    // Next-state, init-digit editing and per-state outputs. A mode press takes priority over an inc step.
    always_comb begin
        state_d    = state_q;
        hour_d     = hour_q;
        min_d      = min_q;
        load       = 1'b0;
        set_active = 1'b0;
        edit_sel   = 2'b00;
        case (state_q)
            RUN: begin
                if (press_q[0]) begin
                    hour_d  = hour_ok({hourdec_now, hourone_now}) ? {hourdec_now, hourone_now} : 8'h00;
                    min_d   = min_ok({mindec_now, minone_now}) ? {mindec_now, minone_now} : 8'h00;
                    state_d = SET_HOUR;
                end
            end
            SET_HOUR: begin
                set_active = 1'b1;
                edit_sel   = 2'b01;
                if (press_q[0])    state_d = SET_MIN;
                else if (inc_step) hour_d  = next_hour(hour_q);
                else if (timeout)  state_d = RUN;
            end
            SET_MIN: begin
                set_active = 1'b1;
                edit_sel   = 2'b10;
                if (press_q[0])    state_d = COMMIT;
                else if (inc_step) min_d   = next_min(min_q);
                else if (timeout)  state_d = RUN;
            end
            COMMIT: begin
                load    = 1'b1;
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // The idle counter runs only inside a set state. Any activity or state change restarts it.
    always_comb begin
        if (!in_set || (state_d != state_q) || press_q[0] || inc_step) idle_d = '0;
        else idle_d = idle_q + TW'(1);
    end

`ifdef AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CNT + 1);
    logic [RW-1:0] rep_q, rep_d;

    assign rep_step = in_set && deb_q[1] && (rep_q == RW'(REPEAT_CNT - 1));

    // The repeat timer runs while inc is held in a set state. It re-phases on each press or step, and on release.
    always_comb begin
        if (!in_set || !deb_q[1] || press_q[1] || rep_step || (state_d != state_q)) rep_d = '0;
        else rep_d = rep_q + RW'(1);
    end

    // Repeat timer register.
    always_ff @(posedge clk) begin
        if (rst) rep_q <= '0;
        else     rep_q <= rep_d;
    end
`else
    assign rep_step = 1'b0;
`endif

    // State, debounce and init-digit registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            deb_dly_q <= '0;
            press_q   <= '0;
            dcnt_q    <= '0;
            state_q   <= RUN;
            hour_q    <= '0;
            min_q     <= '0;
            idle_q    <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_q     <= deb_d;
            deb_dly_q <= deb_dly_d;
            press_q   <= press_d;
            dcnt_q    <= dcnt_d;
            state_q   <= state_d;
            hour_q    <= hour_d;
            min_q     <= min_d;
            idle_q    <= idle_d;
        end
    end

    assign {hourdec_init, hourone_init} = hour_q;
    assign {mindec_init, minone_init}   = min_q;

endmodule
